apple2_bus_master: RTL

Apple II slot-bus initiator for the card's bench and bring-up rig. It accepts single-byte transaction requests on a valid/ready port and replays each one as a native 6502 bus cycle on C7M. Each cycle drives PHI1/PHI0, A, nWE and D, decodes the slot selects (nDEVSEL, nIOSEL, nIOSTRB) for the configured slot, and returns read data. It is the counterpart that drives a slot card's select/register/ROM logic exactly as a motherboard would.

---
 rtl/apple2_bus_master_if.sv | 33 +++
 rtl/apple2_bus_master.sv | 133 +++++++++++++
 2 files changed

// File: rtl/apple2_bus_master_if.sv
// Request/response port and Apple II slot-bus signals for apple2_bus_master.
// The master modport is the bus initiator; the slave modport is the card/requester side.
interface apple2_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic        req_we;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        PHI1;
   logic        PHI0;
   logic [15:0] A;
   logic        nWE;
   logic [7:0]  D_out;
   logic        D_oe;
   logic [7:0]  D_in;
   logic        nDEVSEL;
   logic        nIOSEL;
   logic        nIOSTRB;

   modport master (
      input  req_valid, req_addr, req_we, req_wdata, D_in,
      output req_ready, rsp_valid, rsp_rdata, PHI1, PHI0, A, nWE,
             D_out, D_oe, nDEVSEL, nIOSEL, nIOSTRB
   );

   modport slave (
      output req_valid, req_addr, req_we, req_wdata, D_in,
      input  req_ready, rsp_valid, rsp_rdata, PHI1, PHI0, A, nWE,
             D_out, D_oe, nDEVSEL, nIOSEL, nIOSTRB
   );
endinterface

// File: rtl/apple2_bus_master.sv
// Apple II slot-bus initiator: replays single-byte requests as free-running 6502 bus cycles on C7M.
// Define APPLE2_LONG_CYCLE_EN to stretch every 65th cycle to eight states (T8 in PHI0).
module apple2_bus_master #(
   parameter int          SLOT      = 7,
   parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
   input logic                 C7M,
   input logic                 nRES,
   apple2_bus_master_if.master bus
);

   typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, T7, T8} state_t;

   localparam logic [11:0] DEV_BASE = 12'hC08 + 12'(SLOT);
   localparam logic [7:0]  IO_BASE  = 8'hC0 + 8'(SLOT);

   state_t      state, state_nxt;
   logic        last_state, phi1, phase0, data_phase, accept;
   logic        dev_hit, io_hit, strb_hit;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q, rsp_rdata_q;
   logic        write_q, active_q, rsp_valid_q;
   logic        dev_q, io_q, strb_q;
   logic        d_oe;

`ifdef APPLE2_LONG_CYCLE_EN
   logic [6:0] cycle_cnt;
   logic       long_cycle;

   assign long_cycle = (cycle_cnt == 7'd64);

   // Counts bus cycles 0..64; the count advances as each new cycle begins
   always_ff @(posedge C7M) begin
      if (!nRES)
         cycle_cnt <= 7'd0;
      else if (last_state)
         cycle_cnt <= long_cycle ? 7'd0 : cycle_cnt + 7'd1;
   end
`endif

   always_ff @(posedge C7M) begin
      if (!nRES)
         state <= T1;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      phi1       = 1'b0;
      phase0     = 1'b0;
      data_phase = 1'b0;
      last_state = (state == T7);
`ifdef APPLE2_LONG_CYCLE_EN
      if (long_cycle)
         last_state = (state == T8);
`endif
      case (state)
         T1: begin phi1 = 1'b1; state_nxt = T2; end
         T2: begin phi1 = 1'b1; state_nxt = T3; end
         T3: begin phi1 = 1'b1; state_nxt = T4; end
         T4: begin phase0 = 1'b1; state_nxt = T5; end
         T5: begin phase0 = 1'b1; data_phase = 1'b1; state_nxt = T6; end
         T6: begin phase0 = 1'b1; data_phase = 1'b1; state_nxt = T7; end
         T7: begin
            phase0     = 1'b1;
            data_phase = 1'b1;
            state_nxt  = last_state ? T1 : T8;
         end
         T8: begin phase0 = 1'b1; data_phase = 1'b1; state_nxt = T1; end
      endcase
   end

   // Ready is gated by reset so a request offered during reset is never taken
   assign bus.req_ready = last_state & nRES;
   assign accept        = bus.req_valid & bus.req_ready;

   assign dev_hit  = (bus.req_addr[15:4] == DEV_BASE);
   assign io_hit   = (bus.req_addr[15:8] == IO_BASE);
   assign strb_hit = (bus.req_addr[15:11] == 5'b11001);

   // Cycle boundary: retire the running transaction and latch the next one (or idle)
   always_ff @(posedge C7M) begin
      if (!nRES) begin
         addr_q      <= IDLE_ADDR;
         write_q     <= 1'b0;
         wdata_q     <= 8'h00;
         active_q    <= 1'b0;
         dev_q       <= 1'b0;
         io_q        <= 1'b0;
         strb_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
      end else begin
         rsp_valid_q <= 1'b0;
         if (last_state) begin
            rsp_valid_q <= active_q;
            if (active_q)
               rsp_rdata_q <= write_q ? 8'h00 : bus.D_in;
            if (accept) begin
               addr_q   <= bus.req_addr;
               write_q  <= bus.req_we;
               wdata_q  <= bus.req_wdata;
               active_q <= 1'b1;
               dev_q    <= dev_hit;
               io_q     <= io_hit;
               strb_q   <= strb_hit;
            end else begin
               addr_q   <= IDLE_ADDR;
               write_q  <= 1'b0;
               active_q <= 1'b0;
               dev_q    <= 1'b0;
               io_q     <= 1'b0;
               strb_q   <= 1'b0;
            end
         end
      end
   end

   assign d_oe        = write_q & data_phase;
   assign bus.PHI1    = phi1;
   assign bus.PHI0    = ~phi1;
   assign bus.A       = addr_q;
   assign bus.nWE     = ~write_q;
   assign bus.D_oe    = d_oe;
   assign bus.D_out   = d_oe ? wdata_q : 8'h00;
   assign bus.nDEVSEL = ~(dev_q & phase0);
   assign bus.nIOSEL  = ~(io_q & phase0);
   assign bus.nIOSTRB = ~(strb_q & phase0);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule
